rvr32_mem_arb: RTL
==================

// Module: rvr32_mem_arb
// PURPOSE
//  Two-requester arbiter in front of rvr32_mc. Port 0 (instruction fetch) and port 1 (load/store)
//  share the single valid/ready memory port; one transaction is in flight at a time.
//  Guarantees the mem_valid low gap that rvr32_mc needs to clear its per-transaction state.
//  Adds a ready-timeout watchdog.
// PARAMETERS
//  GAP_CYC      1    mem_valid low cycles between transactions; legal range 1..15
//  TIMEOUT_CYC  255  BUSY cycles without mem_ready before forced completion; 0 disables
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  m0_valid      in   1   port 0 request; held until m0_ready
//  m0_addr       in   32  port 0 byte address
//  m0_wdata      in   32  port 0 write data
//  m0_wstrb      in   4   port 0 byte strobes; 0 = read
//  m0_rdata      out  32  port 0 read data; valid while m0_ready=1
//  m0_ready      out  1   port 0 completion, 1-cycle pulse
//  m1_*          -    -   same set as m0_*, for port 1
//  mem_valid     out  1   to rvr32_mc valid
//  mem_addr      out  32  to rvr32_mc addr
//  mem_wdata     out  32  to rvr32_mc wdata
//  mem_wstrb     out  4   to rvr32_mc wstrb
//  mem_rdata     in   32  from rvr32_mc rdata
//  mem_ready     in   1   from rvr32_mc ready
//  grant         out  2   one-hot owner of the current transaction; 0 when idle
//  err           out  1   1-cycle pulse on watchdog timeout
// BEHAVIOUR
//  Reset (async): state=IDLE, mem_valid=0, grant=0, m0/m1_ready=0, err=0, counters=0, rr_last=0.
//   Reset asserted mid-transaction drops mem_valid immediately; no ready is issued.
//  FSM states are IDLE, BUSY and GAP.
//   IDLE: if any mX_valid is high at the clock edge, latch the winner into grant and go to BUSY.
//   BUSY: mem_valid=1. mem_addr, mem_wdata and mem_wstrb mux combinationally from the granted port.
//    mem_ready=1: mX_ready=mem_ready and mX_rdata=mem_rdata for the granted port, in the same cycle.
//     Next state is GAP.
//    Granted mX_valid dropping before ready is an abort: next state is GAP, no ready is issued,
//     and err stays 0.
//    TIMEOUT_CYC!=0 and the BUSY cycle count reaches TIMEOUT_CYC: granted mX_ready=1 with
//     mX_rdata=32'h0, and err=1, for one cycle. Next state is GAP.
//   GAP: mem_valid=0 for exactly GAP_CYC cycles. The last GAP cycle arbitrates like IDLE:
//    a pending request goes straight to BUSY; otherwise the next state is IDLE.
//  Latency: request to mem_valid is 1 cycle. mem_ready to next mem_valid is GAP_CYC+1 cycles,
//   or GAP_CYC cycles from the ready edge when a request is already pending.
//  Ungranted mX_ready=0 and mX_rdata=0 at all times. grant clears when entering IDLE.
//  Outside BUSY, mem_addr, mem_wdata and mem_wstrb are 0.
//  Arbitration samples only at the IDLE edge or the last GAP edge; requests that rise mid-BUSY wait.
//  Simultaneous requests: port 1 wins (fixed priority) unless RVR32_ARB_RR_EN is defined.
//  The BUSY counter is $clog2(TIMEOUT_CYC+1) bits wide, saturates, and clears on leaving BUSY.
//  The GAP counter is 4 bits wide.
// CONFIGURATION
//  RVR32_ARB_RR_EN defined: round-robin. rr_last records the last granted port.
//   On a tie, the other port wins. rr_last updates on every grant, including aborted ones.
//  RVR32_ARB_RR_EN undefined: fixed priority, port 1 over port 0. Port 0 can starve; rr_last is absent.
// TESTING
//  Single read: m0 read addr=0x100, mem_ready after 3 cycles with rdata=0x12345678.
//   Expected: mem_valid high 1 cycle after m0_valid; m0_ready pulse with 0x12345678; grant=01 -> 00.
//  Tie (fixed priority): m0 and m1 request in the same cycle.
//   Expected: m1 is served first; mem_valid low for exactly GAP_CYC=1 cycle; then m0 is served.
//  Tie (RVR32_ARB_RR_EN): both ports hold valid for 4 transactions.
//   Expected: grant sequence 10, 01, 10, 01.
//  Timeout: TIMEOUT_CYC=8, mem_ready held 0.
//   Expected: after 8 BUSY cycles, m1_ready=1, m1_rdata=0, err=1 for 1 cycle; then GAP.
//  Abort and reset: m0_valid drops in BUSY cycle 2.
//   Expected: no m0_ready; mem_valid low next cycle.
//   Then rst pulse during a m1 BUSY: mem_valid=0 and grant=0 immediately; no ready issued.
//  Partial store: m1 wstrb=4'b0010, wdata=0xAABBCCDD.
//   Expected: mem_wstrb/mem_wdata pass through unchanged; m1_ready pulses exactly once.

Source files
------------

// File: rtl/rvr32_mem_arb.sv
// rvr32_mem_arb: two-port valid/ready arbiter with post-transaction mem_valid gap and ready watchdog
// Define RVR32_ARB_RR_EN for round-robin tie breaking; otherwise port 1 has fixed priority.
module rvr32_mem_arb #(
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [1:0]  grant_o,
  output logic        err_o
);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);
  localparam logic [3:0] GLAST = 4'(GAP_CYC - 1);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, req, win;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic busy, gvalid, abort, tmo, fire, arb;
  logic [31:0] rd;
  assign req = {m1_valid_i, m0_valid_i};
`ifdef RVR32_ARB_RR_EN
  logic rr_last_q, rr_last_d;
  assign win = &req ? (rr_last_q ? 2'b01 : 2'b10) : req;
`else
  assign win = req[1] ? 2'b10 : req;
`endif
  assign busy   = state_q == BUSY;
  assign gvalid = |(grant_q & req);
  assign abort  = busy && !gvalid;
  assign tmo    = busy && (TIMEOUT_CYC != 0) && busy_cnt_q == TMAX;
  assign fire   = busy && gvalid && (mem_ready_i || tmo);
  // the final GAP cycle samples requests exactly like IDLE
  assign arb    = state_q == IDLE || (state_q == GAP && gap_cnt_q == GLAST);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_cnt_q <= '0;
      gap_cnt_q  <= '0;
`ifdef RVR32_ARB_RR_EN
      rr_last_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_cnt_q <= busy_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef RVR32_ARB_RR_EN
      rr_last_q  <= rr_last_d;
`endif
    end
  end
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_cnt_d = '0;
    gap_cnt_d  = '0;
`ifdef RVR32_ARB_RR_EN
    rr_last_d  = (arb && |win) ? win[1] : rr_last_q;
`endif
    if (arb) begin
      state_d = |win ? BUSY : IDLE;
      grant_d = win;
    end else if (state_q == GAP) gap_cnt_d = gap_cnt_q + 4'd1;
    else if (abort || fire) state_d = GAP;
    else busy_cnt_d = busy_cnt_q == TMAX ? busy_cnt_q : busy_cnt_q + 1'b1;
  end
  always_comb begin
    mem_valid_o = busy;
    mem_addr_o  = busy ? (grant_q[1] ? m1_addr_i  : m0_addr_i)  : '0;
    mem_wdata_o = busy ? (grant_q[1] ? m1_wdata_i : m0_wdata_i) : '0;
    mem_wstrb_o = busy ? (grant_q[1] ? m1_wstrb_i : m0_wstrb_i) : '0;
    m0_ready_o  = fire && grant_q[0];
    m1_ready_o  = fire && grant_q[1];
    rd          = mem_ready_i ? mem_rdata_i : '0;
    m0_rdata_o  = m0_ready_o ? rd : '0;
    m1_rdata_o  = m1_ready_o ? rd : '0;
    grant_o     = grant_q;
    err_o       = tmo && gvalid && !mem_ready_i;
  end
endmodule
